// File: rtl/wb_arbiter_pkg.sv
// Shared parameters for the write-back arbiter: default widths, arbitration mode encodings
// and the index-width helper (combinational, no state).
package wb_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 4;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  // A single source still needs one bit to carry its index.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Source-result and register-file write bundle; slave is the arbiter's view, master the surroundings'.
// Pure wiring: no latency, src_ready/rf_ready carry the backpressure.
interface wb_arbiter_if
  import wb_pkg::*;
#(
  parameter int N_SRC      = 3,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) ();
  localparam int SRC_IDX_W = idx_w(N_SRC);

  logic [N_SRC-1:0]            src_valid;
  logic [N_SRC-1:0]            src_ready;
  logic [N_SRC*REG_ADDR_W-1:0] src_dest;
  logic [N_SRC*DATA_W-1:0]     src_value;
  logic                        rf_ready;
  logic                        wb_wb_en;
  logic [REG_ADDR_W-1:0]       wb_dest;
  logic [DATA_W-1:0]           wb_value;
  logic [SRC_IDX_W-1:0]        wb_src;

  modport slave (
    input  src_valid, src_dest, src_value, rf_ready,
    output src_ready, wb_wb_en, wb_dest, wb_value, wb_src
  );

  modport master (
    output src_valid, src_dest, src_value, rf_ready,
    input  src_ready, wb_wb_en, wb_dest, wb_value, wb_src
  );

endinterface

// File: rtl/wb_arbiter_rr.sv
// Combinational round-robin / fixed-priority arbiter: one-hot grant plus encoded index.
// Zero latency; no state, the caller owns the rotation pointer.
module rr_arbiter
  import wb_pkg::*;
#(
  parameter int N    = 3,
  parameter int MODE = PRIO_RR,
  localparam int IW  = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan order starts at ptr and wraps; fixed priority always starts at 0.
  always_comb begin : p_scan
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (MODE == PRIO_FIXED) ? k : int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        grant[c] = 1'b1;
        idx      = IW'(c);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back stage: merges N_SRC result producers into one registered register-file write port.
// One-cycle latency; output holds while rf_ready is low and no source is accepted meanwhile.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int N_SRC         = 3,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int REG_ADDR_W    = REG_ADDR_W_DEF,
  parameter int PRIORITY_MODE = PRIO_RR
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int IW = idx_w(N_SRC);

  logic [IW-1:0]    ptr;
  logic [N_SRC-1:0] grant;
  logic [IW-1:0]    gidx;
  logic             gany;
  logic             can_load;

  rr_arbiter #(
    .N    (N_SRC),
    .MODE (PRIORITY_MODE)
  ) u_arb (
    .req   (bus.src_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // The output slot is free when empty or retiring this cycle, so there is no bubble.
  assign can_load      = !bus.wb_wb_en || bus.rf_ready;
  assign bus.src_ready = (!rst && can_load) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_wb_en <= 1'b0;
      bus.wb_dest  <= '0;
      bus.wb_value <= '0;
      bus.wb_src   <= '0;
      ptr          <= '0;
    end else if (can_load) begin
      if (gany) begin
        bus.wb_wb_en <= 1'b1;
        bus.wb_dest  <= bus.src_dest[int'(gidx)*REG_ADDR_W +: REG_ADDR_W];
        bus.wb_value <= bus.src_value[int'(gidx)*DATA_W +: DATA_W];
        bus.wb_src   <= gidx;
        if (PRIORITY_MODE == PRIO_RR)
          ptr <= (gidx == IW'(N_SRC - 1)) ? '0 : gidx + 1'b1;
      end else begin
        bus.wb_wb_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: round-robin, fixed-priority and single-source instances driven in parallel
// and compared each cycle against a rotation-order reference model.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_arbiter_if #(.N_SRC(3), .DATA_W(32), .REG_ADDR_W(4)) bus0 ();
  wb_arbiter_if #(.N_SRC(3), .DATA_W(32), .REG_ADDR_W(4)) bus1 ();
  wb_arbiter_if #(.N_SRC(1), .DATA_W(32), .REG_ADDR_W(4)) bus2 ();

  wb_arbiter #(.N_SRC(3), .DATA_W(32), .REG_ADDR_W(4), .PRIORITY_MODE(PRIO_RR))
    dut_rr (.clk(clk), .rst(rst), .bus(bus0));
  wb_arbiter #(.N_SRC(3), .DATA_W(32), .REG_ADDR_W(4), .PRIORITY_MODE(PRIO_FIXED))
    dut_fp (.clk(clk), .rst(rst), .bus(bus1));
  wb_arbiter #(.N_SRC(1), .DATA_W(32), .REG_ADDR_W(4), .PRIORITY_MODE(PRIO_RR))
    dut_one (.clk(clk), .rst(rst), .bus(bus2));

  logic [2:0]       tb_valid = '0;
  logic [2:0][3:0]  tb_dest  = '0;
  logic [2:0][31:0] tb_val   = '0;
  logic             tb_rf    = 1'b1;

  int errors = 0;
  int checks = 0;

  // Reference state: dut 0 = round-robin, 1 = fixed priority, 2 = single source.
  bit          m_en   [3] = '{0, 0, 0};
  logic [3:0]  m_dest [3] = '{0, 0, 0};
  logic [31:0] m_val  [3] = '{0, 0, 0};
  int          m_src  [3] = '{0, 0, 0};
  int          m_last [3] = '{2, 2, 0};

  task automatic drive(input logic [2:0] v, input logic rf);
    tb_valid = v;
    tb_rf    = rf;
    bus0.src_valid = v;    bus0.src_dest = tb_dest;    bus0.src_value = tb_val;    bus0.rf_ready = rf;
    bus1.src_valid = v;    bus1.src_dest = tb_dest;    bus1.src_value = tb_val;    bus1.rf_ready = rf;
    bus2.src_valid = v[0]; bus2.src_dest = tb_dest[0]; bus2.src_value = tb_val[0]; bus2.rf_ready = rf;
  endtask

  function automatic int exp_grant(input int d);
    logic [2:0] v;
    int n, i;
    v = (d == 2) ? {2'b00, tb_valid[0]} : tb_valid;
    n = (d == 2) ? 1 : 3;
    for (int k = 0; k < n; k++) begin
      i = (d == 1) ? k : (m_last[d] + 1 + k) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] exp_rdy(input int d);
    int g;
    if (rst) return 3'b000;
    if (m_en[d] && !tb_rf) return 3'b000;
    g = exp_grant(d);
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  function automatic logic [2:0] act_rdy(input int d);
    case (d)
      0:       return bus0.src_ready;
      1:       return bus1.src_ready;
      default: return {2'b00, bus2.src_ready};
    endcase
  endfunction

  function automatic logic [38:0] exp_out(input int d);
    return {m_en[d], m_dest[d], m_val[d], 2'(m_src[d])};
  endfunction

  function automatic logic [38:0] act_out(input int d);
    case (d)
      0:       return {bus0.wb_wb_en, bus0.wb_dest, bus0.wb_value, bus0.wb_src};
      1:       return {bus1.wb_wb_en, bus1.wb_dest, bus1.wb_value, bus1.wb_src};
      default: return {bus2.wb_wb_en, bus2.wb_dest, bus2.wb_value, 1'b0, bus2.wb_src};
    endcase
  endfunction

  // Advance one clock and update the reference from the stimulus that was applied.
  task automatic tick();
    int g [3];
    bit ld [3];
    for (int d = 0; d < 3; d++) begin
      g[d]  = exp_grant(d);
      ld[d] = !m_en[d] || tb_rf;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        m_en[d] = 0; m_dest[d] = '0; m_val[d] = '0; m_src[d] = 0;
        m_last[d] = (d == 2) ? 0 : 2;
      end else if (ld[d]) begin
        if (g[d] >= 0) begin
          m_en[d] = 1; m_dest[d] = tb_dest[g[d]]; m_val[d] = tb_val[g[d]]; m_src[d] = g[d];
          m_last[d] = g[d];
        end else begin
          m_en[d] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'b111, 1'b1);
    for (int c = 0; c < 2; c++) begin
      #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_rdy(d) !== 3'b000) begin
          errors++; $display("FAIL reset_ready dut%0d: got %b want 000", d, act_rdy(d));
        end
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_out(d) !== 39'h0) begin
          errors++; $display("FAIL reset_out dut%0d: got %h want 0", d, act_out(d));
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    tb_dest = {4'd3, 4'd2, 4'd1};
    tb_val  = {32'h33, 32'h22, 32'h11};
    for (int k = 0; k < 6; k++) begin
      drive(3'b111, 1'b1);
      #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_rdy(d) !== exp_rdy(d)) begin
          errors++; $display("FAIL rot_ready dut%0d: got %b want %b", d, act_rdy(d), exp_rdy(d));
        end
      end
      checks++;
      if (bus0.src_ready !== 3'(1 << (k % 3))) begin
        errors++; $display("FAIL rot_pulse k=%0d: got %b want %b", k, bus0.src_ready, 3'(1 << (k % 3)));
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++; $display("FAIL rot_out dut%0d: got %h want %h", d, act_out(d), exp_out(d));
        end
      end
      checks++;
      if (bus0.wb_src !== 2'(k % 3) || bus0.wb_value !== 32'(17 * ((k % 3) + 1)) || bus0.wb_wb_en !== 1'b1) begin
        errors++; $display("FAIL rot_seq k=%0d: got src %0d val %h want src %0d", k, bus0.wb_src, bus0.wb_value, k % 3);
      end
    end
  endtask

  task automatic test_backpressure();
    tb_dest[1] = 4'd4; tb_val[1] = 32'hDEADBEEF;
    tb_dest[2] = 4'd5; tb_val[2] = 32'h55;
    drive(3'b010, 1'b1);
    tick();
    checks++;
    if (bus0.wb_dest !== 4'd4 || bus0.wb_value !== 32'hDEADBEEF) begin
      errors++; $display("FAIL bp_load: got %0d/%h want 4/deadbeef", bus0.wb_dest, bus0.wb_value);
    end
    for (int c = 0; c < 3; c++) begin
      drive(3'b100, 1'b0);
      #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_rdy(d) !== exp_rdy(d)) begin
          errors++; $display("FAIL bp_ready dut%0d: got %b want %b", d, act_rdy(d), exp_rdy(d));
        end
      end
      checks++;
      if (bus0.src_ready !== 3'b000) begin
        errors++; $display("FAIL bp_stall_ready: got %b want 000", bus0.src_ready);
      end
      tick();
      checks++;
      if ({bus0.wb_wb_en, bus0.wb_dest, bus0.wb_value} !== {1'b1, 4'd4, 32'hDEADBEEF}) begin
        errors++; $display("FAIL bp_hold: got %b/%0d/%h want 1/4/deadbeef", bus0.wb_wb_en, bus0.wb_dest, bus0.wb_value);
      end
    end
    drive(3'b100, 1'b1);
    #1;
    checks++;
    if (bus0.src_ready !== 3'b100) begin
      errors++; $display("FAIL bp_release_ready: got %b want 100", bus0.src_ready);
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (act_out(d) !== exp_out(d)) begin
        errors++; $display("FAIL bp_out dut%0d: got %h want %h", d, act_out(d), exp_out(d));
      end
    end
    checks++;
    if (bus0.wb_src !== 2'd2 || bus0.wb_value !== 32'h55) begin
      errors++; $display("FAIL bp_next: got src %0d val %h want 2/55", bus0.wb_src, bus0.wb_value);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 2; c++) begin
      drive(3'b000, 1'b1);
      tick();
      checks++;
      if (bus0.wb_wb_en !== 1'b0 || bus0.wb_value !== 32'h55) begin
        errors++; $display("FAIL idle: got en %b val %h want 0/55", bus0.wb_wb_en, bus0.wb_value);
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++; $display("FAIL idle_out dut%0d: got %h want %h", d, act_out(d), exp_out(d));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] pat [5] = '{3'b001, 3'b010, 3'b101, 3'b101, 3'b111};
    int want [5] = '{0, 1, 2, 0, 1};
    for (int c = 0; c < 5; c++) begin
      drive(pat[c], 1'b1);
      #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_rdy(d) !== exp_rdy(d)) begin
          errors++; $display("FAIL wrap_ready dut%0d: got %b want %b", d, act_rdy(d), exp_rdy(d));
        end
      end
      tick();
      checks++;
      if (bus0.wb_src !== 2'(want[c])) begin
        errors++; $display("FAIL wrap_order step%0d: got %0d want %0d", c, bus0.wb_src, want[c]);
      end
    end
  endtask

  task automatic test_fixed();
    for (int c = 0; c < 4; c++) begin
      drive(3'b101, 1'b1);
      #1;
      checks++;
      if (bus1.src_ready !== 3'b001) begin
        errors++; $display("FAIL fixed_ready: got %b want 001", bus1.src_ready);
      end
      tick();
      checks++;
      if (bus1.wb_src !== 2'd0) begin
        errors++; $display("FAIL fixed_src: got %0d want 0", bus1.wb_src);
      end
    end
    drive(3'b100, 1'b1);
    #1;
    checks++;
    if (bus1.src_ready !== 3'b100) begin
      errors++; $display("FAIL fixed_switch_ready: got %b want 100", bus1.src_ready);
    end
    tick();
    checks++;
    if (bus1.wb_src !== 2'd2) begin
      errors++; $display("FAIL fixed_switch_src: got %0d want 2", bus1.wb_src);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        tb_dest[i] = 4'($urandom);
        tb_val[i]  = $urandom;
      end
      rst = ($urandom_range(49) == 0);
      drive(3'($urandom), $urandom_range(3) != 0);
      #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_rdy(d) !== exp_rdy(d)) begin
          errors++; $display("FAIL rand_ready c=%0d dut%0d: got %b want %b", c, d, act_rdy(d), exp_rdy(d));
        end
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (act_out(d) !== exp_out(d)) begin
          errors++; $display("FAIL rand_out c=%0d dut%0d: got %h want %h", c, d, act_out(d), exp_out(d));
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid();
    tb_dest[1] = 4'd9; tb_val[1] = 32'hCAFE0001;
    drive(3'b010, 1'b1);
    tick();
    checks++;
    if (bus0.wb_wb_en !== 1'b1) begin
      errors++; $display("FAIL rmid_pre: got en %b want 1", bus0.wb_wb_en);
    end
    rst = 1'b1;
    drive(3'b010, 1'b1);
    #1;
    checks++;
    if ({bus0.src_ready, bus1.src_ready, bus2.src_ready} !== 7'b0) begin
      errors++; $display("FAIL rmid_ready: got %b/%b want 000/000", bus0.src_ready, bus1.src_ready);
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (act_out(d) !== 39'h0) begin
        errors++; $display("FAIL rmid_out dut%0d: got %h want 0", d, act_out(d));
      end
    end
    rst = 1'b0;
    drive(3'b010, 1'b1);
    #1;
    checks++;
    if (bus0.src_ready !== 3'b010) begin
      errors++; $display("FAIL rmid_reoffer: got %b want 010", bus0.src_ready);
    end
    tick();
    checks++;
    if ({bus0.wb_wb_en, bus0.wb_src, bus0.wb_dest, bus0.wb_value} !== {1'b1, 2'd1, 4'd9, 32'hCAFE0001}) begin
      errors++; $display("FAIL rmid_write: got %b/%0d/%0d/%h want 1/1/9/cafe0001",
                         bus0.wb_wb_en, bus0.wb_src, bus0.wb_dest, bus0.wb_value);
    end
  endtask

  initial begin
    drive(3'b000, 1'b1);
    @(posedge clk);
    #1;
    test_reset();
    test_rotation();
    test_backpressure();
    test_idle();
    test_wrap();
    test_fixed();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
